// File: rtl/pipe_mips32_fwd_if.sv
// Program-load, debug-read and status bundle of the pipe_mips32_fwd core.
// The bench or host drives the master side; the core is the slave.
interface pipe_mips32_fwd_if #(
   parameter int DATA_W  = 32,
   parameter int IMEM_AW = 10,
   parameter int CNT_W   = 32
);
   logic               prog_we;
   logic [IMEM_AW-1:0] prog_addr;
   logic [31:0]        prog_wdata;
   logic [4:0]         dbg_raddr;
   logic [DATA_W-1:0]  dbg_rdata;
   logic               halted;
   logic [CNT_W-1:0]   retire_cnt;

   modport master (output prog_we, prog_addr, prog_wdata, dbg_raddr,
                   input  dbg_rdata, halted, retire_cnt);
   modport slave  (input  prog_we, prog_addr, prog_wdata, dbg_raddr,
                   output dbg_rdata, halted, retire_cnt);
endinterface

// File: rtl/pipe_mips32_fwd.sv
// 5-stage MIPS32-subset core (IF/ID/EX/MEM/WB) with full forwarding, load-use interlock,
// EX-resolved branches with a 2-slot flush, and separate instruction/data memories.
module pipe_mips32_fwd #(
   parameter int DATA_W     = 32,
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipe_mips32_fwd_if.slave bus
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h02, OP_OR    = 6'h03,
                          OP_SLT  = 6'h04, OP_MUL  = 6'h05, OP_LW   = 6'h08, OP_SW    = 6'h09,
                          OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI = 6'h0C, OP_BNEQZ = 6'h0D,
                          OP_BEQZ = 6'h0E;

   function automatic logic signed [DATA_W-1:0] alu_f(input logic [5:0] op,
                                                      input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
      case (op)
         OP_ADD, OP_ADDI, OP_LW, OP_SW: alu_f = a + b;
         OP_SUB, OP_SUBI:               alu_f = a - b;
         OP_AND:                        alu_f = a & b;
         OP_OR:                         alu_f = a | b;
         OP_SLT, OP_SLTI:               alu_f = (a < b) ? DATA_W'(1) : '0;
         OP_MUL:                        alu_f = a * b;
         default:                       alu_f = '0;
      endcase
   endfunction

   logic [31:0]              imem [IMEM_DEPTH];
   logic signed [DATA_W-1:0] dmem [DMEM_DEPTH];
   logic signed [DATA_W-1:0] rf_q [32];

   logic [IAW-1:0]   pc_q, pc_d;
   logic             halted_q, halt_pend_q;
   logic [CNT_W-1:0] cnt_q;
   logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p4_q;

   logic [31:0]              ir_p1_q;
   logic [IAW-1:0]           npc_p1_q, npc_p2_q;
   logic [5:0]               op_p2_q, op_p3_q;
   logic [4:0]               rs_p2_q, rt_p2_q, dst_p2_q, dst_p3_q, dst_p4_q;
   logic                     wr_p2_q, wr_p3_q, wr_p4_q, hlt_p2_q, hlt_p3_q, hlt_p4_q, lw_p4_q;
   logic signed [DATA_W-1:0] a_p2_q, b_p2_q, imm_p2_q, alu_p3_q, b_p3_q, alu_p4_q, lmd_p4_q;

   logic [5:0]               id_op;
   logic [4:0]               id_rs, id_rt, id_dst;
   logic                     id_rr, id_ri, id_hlt, id_wr, id_use_rt;
   logic signed [DATA_W-1:0] id_a, id_b, wb_data, fwd_a, fwd_b, opb, ex_alu;
   logic                     wb_we, ex_taken, ld_use, stall, id_halt, freeze;
   logic [IAW-1:0]           ex_target;

   // WB: result select; also feeds the ID write-through bypass and EX forwarding
   assign wb_data = lw_p4_q ? lmd_p4_q : alu_p4_q;
   assign wb_we   = vld_p4_q && wr_p4_q && (dst_p4_q != 5'd0);

   // ID: decode and register read
   always_comb begin
      id_op     = ir_p1_q[31:26];
      id_rs     = ir_p1_q[25:21];
      id_rt     = ir_p1_q[20:16];
      id_rr     = (id_op <= OP_MUL);
      id_ri     = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
      id_hlt    = !(id_rr || id_ri || id_op == OP_LW || id_op == OP_SW ||
                    id_op == OP_BNEQZ || id_op == OP_BEQZ);
      id_wr     = id_rr || id_ri || (id_op == OP_LW);
      id_dst    = id_rr ? ir_p1_q[15:11] : id_rt;
      id_use_rt = id_rr || (id_op == OP_SW);
      id_a      = (id_rs == 5'd0) ? '0 : (wb_we && dst_p4_q == id_rs) ? wb_data : rf_q[id_rs];
      id_b      = (id_rt == 5'd0) ? '0 : (wb_we && dst_p4_q == id_rt) ? wb_data : rf_q[id_rt];
   end

   // EX: operand forwarding (EX/MEM before MEM/WB), ALU and branch resolution
   always_comb begin
      fwd_a = a_p2_q;
      if (vld_p3_q && wr_p3_q && dst_p3_q != 5'd0 && dst_p3_q == rs_p2_q) fwd_a = alu_p3_q;
      else if (wb_we && dst_p4_q == rs_p2_q)                              fwd_a = wb_data;
      fwd_b = b_p2_q;
      if (vld_p3_q && wr_p3_q && dst_p3_q != 5'd0 && dst_p3_q == rt_p2_q) fwd_b = alu_p3_q;
      else if (wb_we && dst_p4_q == rt_p2_q)                              fwd_b = wb_data;
      opb       = (op_p2_q >= OP_LW && op_p2_q <= OP_SLTI) ? imm_p2_q : fwd_b;
      ex_alu    = alu_f(op_p2_q, fwd_a, opb);
      ex_taken  = vld_p2_q && (((op_p2_q == OP_BEQZ) && (fwd_a == '0)) ||
                               ((op_p2_q == OP_BNEQZ) && (fwd_a != '0)));
      ex_target = npc_p2_q + imm_p2_q[IAW-1:0];
   end

   // Hazard control: a taken branch overrides both the load-use stall and a halt in ID
   always_comb begin
      ld_use   = vld_p1_q && vld_p2_q && (op_p2_q == OP_LW) &&
                 ((!id_hlt && id_rs == rt_p2_q) || (id_use_rt && id_rt == rt_p2_q));
      stall    = ld_use && !ex_taken;
      id_halt  = vld_p1_q && id_hlt && !ex_taken;
      freeze   = halt_pend_q || id_halt;
      pc_d     = pc_q;
      vld_p1_d = vld_p1_q;
      if (ex_taken) begin
         pc_d     = ex_target;
         vld_p1_d = 1'b0;
      end else if (stall) begin
         vld_p1_d = vld_p1_q;
      end else if (freeze) begin
         vld_p1_d = 1'b0;
      end else begin
         pc_d     = pc_q + IAW'(1);
         vld_p1_d = 1'b1;
      end
      vld_p2_d = vld_p1_q && !ex_taken && !stall;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= '0;
         halted_q    <= 1'b0;
         halt_pend_q <= 1'b0;
         cnt_q       <= '0;
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         vld_p3_q    <= 1'b0;
         vld_p4_q    <= 1'b0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (!halted_q) begin
         pc_q        <= pc_d;
         halt_pend_q <= halt_pend_q || id_halt;
         vld_p1_q    <= vld_p1_d;
         vld_p2_q    <= vld_p2_d;
         vld_p3_q    <= vld_p2_q;
         vld_p4_q    <= vld_p3_q;
         if (vld_p4_q)             cnt_q            <= cnt_q + CNT_W'(1);
         if (vld_p4_q && hlt_p4_q) halted_q         <= 1'b1;
         if (wb_we)                rf_q[dst_p4_q]   <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.prog_we) imem[bus.prog_addr] <= bus.prog_wdata;
      if (!halted_q) begin
         // IF/ID
         if (!stall) begin
            ir_p1_q  <= imem[pc_q];
            npc_p1_q <= pc_q + IAW'(1);
         end
         // ID/EX
         op_p2_q  <= id_op;
         rs_p2_q  <= id_rs;
         rt_p2_q  <= id_rt;
         dst_p2_q <= id_dst;
         wr_p2_q  <= id_wr;
         hlt_p2_q <= id_hlt;
         a_p2_q   <= id_a;
         b_p2_q   <= id_b;
         imm_p2_q <= {{(DATA_W-16){ir_p1_q[15]}}, ir_p1_q[15:0]};
         npc_p2_q <= npc_p1_q;
         // EX/MEM
         op_p3_q  <= op_p2_q;
         alu_p3_q <= ex_alu;
         b_p3_q   <= fwd_b;
         dst_p3_q <= dst_p2_q;
         wr_p3_q  <= wr_p2_q;
         hlt_p3_q <= hlt_p2_q;
         // MEM/WB
         if (vld_p3_q && op_p3_q == OP_SW) dmem[alu_p3_q[DAW-1:0]] <= b_p3_q;
         lmd_p4_q <= dmem[alu_p3_q[DAW-1:0]];
         alu_p4_q <= alu_p3_q;
         lw_p4_q  <= (op_p3_q == OP_LW);
         dst_p4_q <= dst_p3_q;
         wr_p4_q  <= wr_p3_q;
         hlt_p4_q <= hlt_p3_q;
      end
   end

   assign bus.dbg_rdata  = (bus.dbg_raddr == 5'd0) ? '0 : rf_q[bus.dbg_raddr];
   assign bus.halted     = halted_q;
   assign bus.retire_cnt = cnt_q;
endmodule
